// File: rtl/CorePack.sv
// Shared core types: memory-op encoding, data-memory agent states and helpers.
package CorePack;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_enum;

  typedef enum logic [2:0] {
    DMEM_IDLE  = 3'd0,
    DMEM_REQ0  = 3'd1,
    DMEM_WAIT0 = 3'd2,
    DMEM_REQ1  = 3'd3,
    DMEM_WAIT1 = 3'd4,
    DMEM_RESP  = 3'd5
  } dmem_state_enum;

  // Access size in bytes; MEM_NO reports 1 but never reaches memory.
  function automatic logic [3:0] mem_size(input mem_op_enum op);
    case (op)
      MEM_H, MEM_UH: mem_size = 4'd2;
      MEM_W, MEM_UW: mem_size = 4'd4;
      MEM_D:         mem_size = 4'd8;
      default:       mem_size = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment for the data-memory agent: store masks/data per beat,
// split detection, and load-result extraction with sign/zero extension.
module dmem_align
  import CorePack::*;
(
  input  mem_op_enum  op_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rbuf0_i,
  input  logic [63:0] rbuf1_i,
  output logic [7:0]  mask0_o,
  output logic [7:0]  mask1_o,
  output logic [63:0] wdata0_o,
  output logic [63:0] wdata1_o,
  output logic        split_o,
  output logic [63:0] rdata_o
);

  logic [3:0]   size;
  logic [15:0]  base_mask;
  logic [15:0]  mask0_wide;
  logic [15:0]  mask1_wide;
  logic [5:0]   bit_shift;
  logic [127:0] pair;
  logic [63:0]  raw;

  // Masks, shifted store data and split flag for both beats.
  always_comb begin
    size       = mem_size(op_i);
    base_mask  = (16'd1 << size) - 16'd1;
    mask0_wide = base_mask << offset_i;
    mask1_wide = base_mask >> (4'd8 - {1'b0, offset_i});
    mask0_o    = mask0_wide[7:0];
    mask1_o    = mask1_wide[7:0];
    split_o    = ({1'b0, offset_i} + size) > 4'd8;
    bit_shift  = {offset_i, 3'b000};
    wdata0_o   = wdata_i << bit_shift;
    // A zero offset never splits; avoid relying on a full-width shift.
    wdata1_o   = (offset_i == 3'd0) ? '0 : wdata_i >> (7'd64 - {1'b0, bit_shift});
  end

  // Load result: realign the two captured beats, then truncate and extend.
  always_comb begin
    pair = {rbuf1_i, rbuf0_i} >> bit_shift;
    raw  = pair[63:0];
    case (op_i)
      MEM_B:   rdata_o = {{56{raw[7]}}, raw[7:0]};
      MEM_H:   rdata_o = {{48{raw[15]}}, raw[15:0]};
      MEM_W:   rdata_o = {{32{raw[31]}}, raw[31:0]};
      MEM_D:   rdata_o = raw;
      MEM_UB:  rdata_o = {56'd0, raw[7:0]};
      MEM_UH:  rdata_o = {48'd0, raw[15:0]};
      MEM_UW:  rdata_o = {32'd0, raw[31:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_agent.sv
// Data-memory responder: accepts one core load/store, issues one or two
// aligned 64-bit memory beats, and returns an extended load result.
module dmem_agent
  import CorePack::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  mem_op_enum      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  dmem_state_enum  state_q;
  mem_op_enum      op_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rbuf0_q;
  logic [XLEN-1:0] rbuf1_q;

  logic [7:0]      mask0;
  logic [7:0]      mask1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic            split;
  logic [XLEN-1:0] load_data;

  logic            in_req;
  logic            beat1;
  logic [XLEN-1:0] beat_base;

  dmem_align u_align (
    .op_i     (op_q),
    .offset_i (addr_q[2:0]),
    .wdata_i  (wdata_q),
    .rbuf0_i  (rbuf0_q),
    .rbuf1_i  (rbuf1_q),
    .mask0_o  (mask0),
    .mask1_o  (mask1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .split_o  (split),
    .rdata_o  (load_data)
  );

  // Transaction FSM: latch request, run up to two beats, pulse response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DMEM_IDLE;
      op_q    <= MEM_NO;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf0_q <= '0;
      rbuf1_q <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_op == MEM_NO) state_q <= DMEM_RESP;
            else                  state_q <= DMEM_REQ0;
          end
        end
        DMEM_REQ0: if (mem_req_ready) state_q <= DMEM_WAIT0;
        DMEM_WAIT0: begin
          if (mem_resp_valid) begin
            rbuf0_q <= mem_rdata;
            if (split) state_q <= DMEM_REQ1;
            else       state_q <= DMEM_RESP;
          end
        end
        DMEM_REQ1: if (mem_req_ready) state_q <= DMEM_WAIT1;
        DMEM_WAIT1: begin
          if (mem_resp_valid) begin
            rbuf1_q <= mem_rdata;
            state_q <= DMEM_RESP;
          end
        end
        DMEM_RESP: state_q <= DMEM_IDLE;
        default:   state_q <= DMEM_IDLE;
      endcase
    end
  end

  // Outputs decode only flops, so they are glitch-free and reset to idle values.
  always_comb begin
    in_req        = (state_q == DMEM_REQ0) || (state_q == DMEM_REQ1);
    beat1         = (state_q == DMEM_REQ1);
    beat_base     = {addr_q[XLEN-1:3], 3'b000};
    req_ready     = (state_q == DMEM_IDLE);
    resp_valid    = (state_q == DMEM_RESP);
    resp_rdata    = (resp_valid && !we_q) ? load_data : '0;
    mem_req_valid = in_req;
    mem_we        = in_req && we_q;
    mem_addr      = '0;
    mem_wmask     = '0;
    mem_wdata     = '0;
    if (in_req) begin
      // Second beat wraps modulo 2^XLEN by plain addition.
      mem_addr = beat1 ? beat_base + XLEN'(8) : beat_base;
      if (we_q) begin
        mem_wmask = beat1 ? mask1 : mask0;
        mem_wdata = beat1 ? wdata1 : wdata0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_agent.sv
// Scoreboard bench for dmem_agent with a small handshaking memory model.
module tb_dmem_agent;
  import CorePack::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  mem_op_enum  req_op = MEM_NO;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;

  dmem_agent #(.XLEN(64)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    int unsigned cyc;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [63:0] rdata_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned beats_seen = 0;
  int unsigned stall_cycles = 0;
  int unsigned resp_budget = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: optional stall before ready, response one cycle after handshake.
  initial begin : mem_model
    logic hs;
    logic hs_we;
    forever begin
      @(negedge clk);
      hs    = mem_req_valid && mem_req_ready;
      hs_we = mem_we;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h5A5A_5A5A_5A5A_5A5A;
      if (hs && resp_budget > 0) begin
        resp_budget--;
        mem_resp_valid = 1'b1;
        if (hs_we)                  mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        else if (rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
        else                         mem_rdata = '0;
      end
      if (mem_req_valid) begin
        if (stall_cycles > 0) begin
          mem_req_ready = 1'b0;
          stall_cycles--;
        end else begin
          mem_req_ready = 1'b1;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
    end
  end

  // Monitor: compare every presented beat and response against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_req_valid) begin
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {63'd0, mem_req_valid}, 64'd0);
        end else begin
          chk("beat_addr",  mem_addr,             beat_q[0].addr);
          chk("beat_we",    {63'd0, mem_we},      {63'd0, beat_q[0].we});
          chk("beat_wmask", {56'd0, mem_wmask},   {56'd0, beat_q[0].mask});
          chk("beat_wdata", mem_wdata,            beat_q[0].wdata);
          if (mem_req_ready) begin
            void'(beat_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          chk("resp_rdata", resp_rdata,    resp_q[0].rdata);
          chk("resp_cycle", 64'(cyc),      64'(resp_q[0].cyc));
          void'(resp_q.pop_front());
        end
      end
    end
  end

  task automatic exp_beat(input logic [63:0] addr, input logic we,
                          input logic [7:0] mask, input logic [63:0] wdata);
    beat_q.push_back('{addr, we, mask, wdata});
  endtask

  task automatic issue(input logic we, input mem_op_enum op, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rexp,
                       input int unsigned lat);
    int unsigned guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    resp_q.push_back('{rexp, cyc + lat});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = MEM_NO;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wait_done();
    int unsigned guard = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (resp_q.size() != 0 || beat_q.size() != 0) begin
      chk("done_timeout", 64'(resp_q.size() + beat_q.size()), 64'd0);
      resp_q.delete();
      beat_q.delete();
      rdata_q.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"},     {63'd0, req_ready},     64'd1);
    chk({tag, "_resp_valid"},    {63'd0, resp_valid},    64'd0);
    chk({tag, "_resp_rdata"},    resp_rdata,             64'd0);
    chk({tag, "_mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    chk({tag, "_mem_we"},        {63'd0, mem_we},        64'd0);
    chk({tag, "_mem_addr"},      mem_addr,               64'd0);
    chk({tag, "_mem_wdata"},     mem_wdata,              64'd0);
    chk({tag, "_mem_wmask"},     {56'd0, mem_wmask},     64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int unsigned b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Aligned LD
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h8877_6655_4433_2211);
    issue(1'b0, MEM_D, 64'h1000, 64'h0, 64'h8877_6655_4433_2211, 3);
    wait_done();

    // LB / LBU of byte 3 = 0xF0
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h0000_0000_F000_0000);
    issue(1'b0, MEM_B, 64'h1003, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 3);
    wait_done();
    exp_beat(64'h1000, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h0000_0000_F000_0000);
    issue(1'b0, MEM_UB, 64'h1003, 64'h0, 64'h0000_0000_0000_00F0, 3);
    wait_done();

    // Split SW at 0x2006
    exp_beat(64'h2000, 1'b1, 8'hC0, 64'hCCDD_0000_0000_0000);
    exp_beat(64'h2008, 1'b1, 8'h03, 64'h0000_0000_0000_AABB);
    issue(1'b1, MEM_W, 64'h2006, 64'h0000_0000_AABB_CCDD, 64'h0, 5);
    wait_done();

    // Split LHU at 0x3007
    exp_beat(64'h3000, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h3008, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h34AA_BBCC_DDEE_FF00);
    rdata_q.push_back(64'h5566_7788_99AA_BB12);
    issue(1'b0, MEM_UH, 64'h3007, 64'h0, 64'h0000_0000_0000_1234, 5);
    wait_done();

    // SD with ready held low for 4 cycles in REQ0
    b0 = beats_seen;
    stall_cycles = 4;
    exp_beat(64'h4000, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    issue(1'b1, MEM_D, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 7);
    wait_done();
    chk("stall_one_beat", 64'(beats_seen - b0), 64'd1);

    // Split LD wrapping past the top of the address space
    exp_beat(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h0000_0000_0000_0000, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h4433_2211_9999_9999);
    rdata_q.push_back(64'h7777_7777_8877_6655);
    issue(1'b0, MEM_D, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h8877_6655_4433_2211, 5);
    wait_done();

    // LW sign extension
    exp_beat(64'h5000, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h8000_0001_0000_0000);
    issue(1'b0, MEM_W, 64'h5004, 64'h0, 64'hFFFF_FFFF_8000_0001, 3);
    wait_done();

    // LH ending exactly at the boundary: no split
    b0 = beats_seen;
    exp_beat(64'h5800, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h8001_0000_0000_0000);
    issue(1'b0, MEM_H, 64'h5806, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 3);
    wait_done();
    chk("boundary_one_beat", 64'(beats_seen - b0), 64'd1);

    // SB at offset 5
    exp_beat(64'h6000, 1'b1, 8'h20, 64'hFFFF_5A00_0000_0000);
    issue(1'b1, MEM_B, 64'h6005, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 3);
    wait_done();

    // SH at offset 7: one byte per beat
    exp_beat(64'h6800, 1'b1, 8'h80, 64'hEF00_0000_0000_0000);
    exp_beat(64'h6808, 1'b1, 8'h01, 64'h0000_0000_0000_00BE);
    issue(1'b1, MEM_H, 64'h6807, 64'h0000_0000_0000_BEEF, 64'h0, 5);
    wait_done();

    // MEM_NO (even flagged as a store): no beats, response next cycle
    b0 = beats_seen;
    issue(1'b1, MEM_NO, 64'h7777, 64'h1234, 64'h0, 1);
    wait_done();
    chk("memno_no_beat", 64'(beats_seen - b0), 64'd0);

    // Reset during WAIT1 of a split load
    b0 = beats_seen;
    resp_budget = 1;
    exp_beat(64'h7000, 1'b0, 8'h00, 64'h0);
    exp_beat(64'h7008, 1'b0, 8'h00, 64'h0);
    rdata_q.push_back(64'h1111_2222_3333_4444);
    issue(1'b0, MEM_D, 64'h7004, 64'h0, 64'h0, 5);
    begin
      int unsigned guard = 0;
      while (beats_seen != b0 + 2 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("reset_reach_wait1", 64'(beats_seen - b0), 64'd2);
    end
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle_outputs("abort");
    resp_q.delete();
    beat_q.delete();
    rdata_q.delete();
    resp_budget = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    b0 = beats_seen;
    issue(1'b0, MEM_NO, 64'h0, 64'h0, 64'h0, 1);
    wait_done();
    chk("post_reset_no_beat", 64'(beats_seen - b0), 64'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
